// File: rtl/count_checker.sv
// count_checker: locks onto an incrementing counter stream and flags
// any sample that is not the previous value plus one (mod 2^WIDTH).
//
// Ports:
//   clk       rising-edge clock
//   clr_n     asynchronous active-low reset
//   cnt_clr   counter's synchronous clear; restarts tracking from 0
//   en        sample strobe; cnt_in is examined only when high
//   cnt_in    observed counter value
//   locked    high while in LOCK
//   err       one-cycle pulse on a mismatch seen in LOCK
//   fault     sticky error flag, cleared on relock or cnt_clr
//   err_cnt   saturating error count
//   expected  value the next sample must equal
//   state     00 IDLE, 01 SYNC, 10 LOCK
//
// Build option: define COUNT_CHECKER_ERRCNT_EN to keep the err_cnt
// register. Without it, err_cnt is tied to zero.

module count_checker #(
    parameter int WIDTH    = 8,
    parameter int ERR_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             cnt_clr,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             locked,
    output logic             err,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SYNC = 2'b01,
        LOCK = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       match_next;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             fault_q, fault_d;
    logic             hit;

    assign hit        = (cnt_in == exp_q);
    assign match_next = match_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        match_d  = match_q;
        locked_d = locked_q;
        fault_d  = fault_q;
        err_d    = 1'b0;
        if (cnt_clr) begin
            // A counter clear is a legal restart at zero.
            state_d  = SYNC;
            exp_d    = '0;
            match_d  = '0;
            fault_d  = 1'b0;
            locked_d = 1'b0;
        end else if (en) begin
            unique case (state_q)
                IDLE: begin
                    state_d = SYNC;
                    exp_d   = cnt_in + WIDTH'(1);
                    match_d = '0;
                end
                SYNC: begin
                    if (hit) begin
                        exp_d   = exp_q + WIDTH'(1);
                        match_d = match_next;
                        if (match_next == 4'(LOCK_CNT)) begin
                            state_d  = LOCK;
                            locked_d = 1'b1;
                            fault_d  = 1'b0;
                        end
                    end else begin
                        // Re-seed silently; errors only count in LOCK.
                        exp_d   = cnt_in + WIDTH'(1);
                        match_d = '0;
                    end
                end
                LOCK: begin
                    if (hit) begin
                        exp_d = exp_q + WIDTH'(1);
                    end else begin
                        err_d    = 1'b1;
                        fault_d  = 1'b1;
                        state_d  = SYNC;
                        exp_d    = cnt_in + WIDTH'(1);
                        match_d  = '0;
                        locked_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            match_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            fault_q  <= fault_d;
        end
    end

`ifdef COUNT_CHECKER_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign state    = state_q;
    assign expected = exp_q;
    assign locked   = locked_q;
    assign err      = err_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: scoreboard bench for count_checker.
// A reference model queues expected outputs per driven edge.

module tb_count_checker;

    localparam int LOCKN = 2;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       en = 1'b0;
    logic [7:0] cnt_in = '0;
    logic       locked;
    logic       err;
    logic       fault;
    logic [7:0] err_cnt;
    logic [7:0] expected;
    logic [1:0] state;

    count_checker #(
        .WIDTH(8),
        .ERR_W(8),
        .LOCK_CNT(LOCKN)
    ) dut (
        .clk(clk),
        .clr_n(clr_n),
        .cnt_clr(cnt_clr),
        .en(en),
        .cnt_in(cnt_in),
        .locked(locked),
        .err(err),
        .fault(fault),
        .err_cnt(err_cnt),
        .expected(expected),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       locked;
        logic       err;
        logic       fault;
        logic [7:0] err_cnt;
        logic [7:0] expected;
        logic [1:0] state;
    } obs_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   err_pulses = 0;

    logic [1:0] m_state;
    logic [7:0] m_exp;
    int         m_match;
    logic       m_locked;
    logic       m_err;
    logic       m_fault;
    logic [7:0] m_errcnt;

    task automatic model_reset();
        m_state  = 2'b00;
        m_exp    = 8'd0;
        m_match  = 0;
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_fault  = 1'b0;
        m_errcnt = 8'd0;
    endtask

    task automatic model_step(input logic c, input logic e,
                              input logic [7:0] v);
        m_err = 1'b0;
        if (c) begin
            m_state  = 2'b01;
            m_exp    = 8'd0;
            m_match  = 0;
            m_fault  = 1'b0;
            m_locked = 1'b0;
        end else if (e) begin
            if (m_state == 2'b00) begin
                m_state = 2'b01;
                m_exp   = v + 8'd1;
                m_match = 0;
            end else if (m_state == 2'b01) begin
                if (v == m_exp) begin
                    m_match = m_match + 1;
                    m_exp   = m_exp + 8'd1;
                    if (m_match == LOCKN) begin
                        m_state  = 2'b10;
                        m_locked = 1'b1;
                        m_fault  = 1'b0;
                    end
                end else begin
                    m_exp   = v + 8'd1;
                    m_match = 0;
                end
            end else begin
                if (v == m_exp) begin
                    m_exp = m_exp + 8'd1;
                end else begin
                    m_err    = 1'b1;
                    m_fault  = 1'b1;
`ifdef COUNT_CHECKER_ERRCNT_EN
                    if (m_errcnt != 8'hff) m_errcnt = m_errcnt + 8'd1;
`endif
                    m_state  = 2'b01;
                    m_exp    = v + 8'd1;
                    m_match  = 0;
                    m_locked = 1'b0;
                end
            end
        end
    endtask

    // Drive one edge, predict it, and leave time for the monitor.
    task automatic drive(input logic c, input logic e,
                         input logic [7:0] v);
        obs_t o;
        @(negedge clk);
        cnt_clr = c;
        en      = e;
        cnt_in  = v;
        model_step(c, e, v);
        o = '{m_locked, m_err, m_fault, m_errcnt, m_exp, m_state};
        sb.push_back(o);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        obs_t want;
        obs_t got;
        #1;
        if (err === 1'b1) err_pulses++;
        if (sb.size() > 0) begin
            want = sb.pop_front();
            got  = '{locked, err, fault, err_cnt, expected, state};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sb t=%0t got=%h want=%h", $time, got, want);
            end
        end
    end

    task automatic test_reset();
        model_reset();
        #1;
        checks++;
        if ({locked, err, fault, err_cnt, expected, state} !== '0) begin
            errors++;
            $display("FAIL reset got st=%b exp=%0d want 0", state, expected);
        end
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_clear_lock();
        int p0;
        p0 = err_pulses;
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 8'd0);
        checks++;
        if (state !== 2'b01 || expected !== 8'd0) begin
            errors++;
            $display("FAIL clr_sync got st=%b exp=%0d want 01/0",
                     state, expected);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'(i));
            if (i == 2) begin
                checks++;
                if (locked !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_at2 got %b want 1", locked);
                end
            end
        end
        checks++;
        if (expected !== 8'd4 || err_pulses != p0) begin
            errors++;
            $display("FAIL lock_exp got exp=%0d errs=%0d want 4/%0d",
                     expected, err_pulses, p0);
        end
    endtask

    task automatic test_wrap();
        int p0;
        p0 = err_pulses;
        for (int v = 4; v < 258; v++) drive(1'b0, 1'b1, 8'(v));
        checks++;
        if (expected !== 8'd2 || locked !== 1'b1 || err_pulses != p0) begin
            errors++;
            $display("FAIL wrap got exp=%0d lk=%b errs=%0d want 2/1/%0d",
                     expected, locked, err_pulses, p0);
        end
    endtask

    task automatic test_mismatch();
        for (int v = 2; v < 10; v++) drive(1'b0, 1'b1, 8'(v));
        drive(1'b0, 1'b1, 8'd13);
        checks++;
        if (err !== 1'b1 || fault !== 1'b1 || locked !== 1'b0 ||
            expected !== 8'd14) begin
            errors++;
            $display("FAIL mism got e=%b f=%b lk=%b exp=%0d want 1/1/0/14",
                     err, fault, locked, expected);
        end
        checks++;
`ifdef COUNT_CHECKER_ERRCNT_EN
        if (err_cnt !== 8'd1) begin
`else
        if (err_cnt !== 8'd0) begin
`endif
            errors++;
            $display("FAIL mism_cnt got %0d", err_cnt);
        end
        drive(1'b0, 1'b0, 8'd0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got %b want 0", err);
        end
        drive(1'b0, 1'b1, 8'd14);
        drive(1'b0, 1'b1, 8'd15);
        checks++;
        if (locked !== 1'b1 || fault !== 1'b0) begin
            errors++;
            $display("FAIL relock got lk=%b f=%b want 1/0", locked, fault);
        end
    endtask

    task automatic test_clr_priority();
        drive(1'b1, 1'b1, 8'd99);
        checks++;
        if (err !== 1'b0 || state !== 2'b01 || expected !== 8'd0) begin
            errors++;
            $display("FAIL clr_pri got e=%b st=%b exp=%0d want 0/01/0",
                     err, state, expected);
        end
        drive(1'b0, 1'b1, 8'd0);
        drive(1'b0, 1'b1, 8'd1);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_relock got %b want 1", locked);
        end
    endtask

    task automatic test_saturate();
        int p0;
        logic [7:0] e;
        p0 = err_pulses;
        for (int i = 0; i < 300; i++) begin
            e = m_exp;
            drive(1'b0, 1'b1, e + 8'd3);
            drive(1'b0, 1'b1, e + 8'd4);
            drive(1'b0, 1'b1, e + 8'd5);
        end
        checks++;
        if (err_pulses - p0 != 300) begin
            errors++;
            $display("FAIL sat_pulses got %0d want 300", err_pulses - p0);
        end
        checks++;
`ifdef COUNT_CHECKER_ERRCNT_EN
        if (err_cnt !== 8'd255) begin
`else
        if (err_cnt !== 8'd0) begin
`endif
            errors++;
            $display("FAIL sat_cnt got %0d", err_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        @(negedge clk);
        clr_n = 1'b0;
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 8'd0);
        drive(1'b0, 1'b1, 8'd1);
        for (int i = 0; i < 3; i++) begin
            e = m_exp;
            drive(1'b0, 1'b1, e + 8'd7);
            drive(1'b0, 1'b1, e + 8'd8);
            drive(1'b0, 1'b1, e + 8'd9);
        end
        checks++;
`ifdef COUNT_CHECKER_ERRCNT_EN
        if (locked !== 1'b1 || err_cnt !== 8'd3) begin
`else
        if (locked !== 1'b1 || err_cnt !== 8'd0) begin
`endif
            errors++;
            $display("FAIL pre_rst got lk=%b cnt=%0d", locked, err_cnt);
        end
        @(negedge clk);
        #1;
        clr_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({locked, err, fault, err_cnt, expected, state} !== '0) begin
            errors++;
            $display("FAIL async_rst got lk=%b cnt=%0d exp=%0d st=%b",
                     locked, err_cnt, expected, state);
        end
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clear_lock();
        test_wrap();
        test_mismatch();
        test_clr_priority();
        test_saturate();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
